// File: rtl/ccff_chain_loader.sv
// Loads one tile row's configuration-flip-flop chain from a word stream and reads back what falls out of it.
// Latency: each accepted word reaches ccff_head one cycle after its SHIFT cycle, and a readback word follows its last captured bit by one cycle.
// Backpressure: cfg_ready is high only in FETCH, and the chain stalls while the source starves. rb_valid has no backpressure.
//
// Ports:
//   prog_clk, pReset        programming clock; asynchronous active-high reset
//   start, abort            begin a load (ignored unless idle); return to idle (abort wins)
//   cfg_data/valid/ready    bitstream words, shifted LSB first
//   config_enable/ccff_head registered chain shift enable and serial data
//   ccff_tail               serial data leaving the chain
//   rb_data/rb_valid        readback words, first shifted-out bit in bit 0
//   busy/done/err           busy in FETCH/SHIFT; sticky done; sticky starvation timeout
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              config_enable,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BC_W = $clog2(CHAIN_LEN + 1);
  localparam int WI_W = $clog2(WORD_W);
  localparam int ST_W = $clog2(TIMEOUT + 1);

  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(CHAIN_LEN - 1);
  localparam logic [WI_W-1:0] WI_LAST  = WI_W'(WORD_W - 1);
  localparam logic [ST_W-1:0] ST_LIMIT = ST_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Load-side state
  logic [WORD_W-1:0] sr;     // word being serialised
  logic [WI_W-1:0]   wi;     // bit index within sr
  logic [BC_W-1:0]   bc;     // bits issued so far this load
  logic [ST_W-1:0]   stall;  // consecutive starved FETCH cycles
  logic [ST_W-1:0]   stall_inc;

  // Readback-side state. This state runs off the registered config_enable, so it trails the load side by one cycle.
  logic [WORD_W-1:0] rb_acc;
  logic [WI_W-1:0]   gi;     // bit position within the current readback group
  logic [BC_W-1:0]   cc;     // bits captured so far this load
  logic [WORD_W-1:0] rb_next;
  logic              group_end;

  // FSM control strobes
  logic do_start;
  logic do_accept;
  logic do_timeout;
  logic do_shift;
  logic last_bit;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_accept  = 1'b0;
    do_timeout = 1'b0;
    do_shift   = 1'b0;
    last_bit   = 1'b0;
    stall_inc  = stall + 1'b1;
    cfg_ready  = (state == FETCH);
    busy       = (state != IDLE);

    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            do_start   = 1'b1;
            state_next = FETCH;
          end
        end
        FETCH: begin
          if (cfg_valid) begin
            do_accept  = 1'b1;
            state_next = SHIFT;
          end else if (stall_inc == ST_LIMIT) begin
            do_timeout = 1'b1;
            state_next = IDLE;
          end
        end
        SHIFT: begin
          do_shift = 1'b1;
          // The bit-count test comes first. This discards the unused upper bits of a short final word.
          if (bc == BC_LAST) begin
            last_bit   = 1'b1;
            state_next = IDLE;
          end else if (wi == WI_LAST) begin
            state_next = FETCH;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser: word register, counters, chain drive, status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sr            <= '0;
      wi            <= '0;
      bc            <= '0;
      stall         <= '0;
      config_enable <= 1'b0;
      ccff_head     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      // The chain sees the bit one cycle after the SHIFT cycle that chose it.
      config_enable <= do_shift;
      if (do_shift) begin
        ccff_head <= sr[wi];
      end

      if (do_accept) begin
        sr <= cfg_data;
      end

      if (abort || do_accept) begin
        wi <= '0;
      end else if (do_shift) begin
        wi <= wi + 1'b1;
      end

      if (abort || do_start || last_bit) begin
        bc <= '0;
      end else if (do_shift) begin
        bc <= bc + 1'b1;
      end

      if (abort || do_start || do_accept || do_timeout) begin
        stall <= '0;
      end else if (state == FETCH) begin
        stall <= stall_inc;
      end

      // done rises together with the enable that carries the last bit.
      if (do_start) begin
        done <= 1'b0;
      end else if (last_bit) begin
        done <= 1'b1;
      end

      if (do_start) begin
        err <= 1'b0;
      end else if (do_timeout) begin
        err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Readback capture
  // ---------------------------------------------------------------------
  assign rb_next   = rb_acc | ({{(WORD_W-1){1'b0}}, ccff_tail} << gi);
  assign group_end = (gi == WI_LAST) || (cc == BC_LAST);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      rb_acc   <= '0;
      gi       <= '0;
      cc       <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (abort) begin
        rb_acc <= '0;
        gi     <= '0;
        cc     <= '0;
      end else if (config_enable) begin
        // The last bit of a load can still be in flight during the first IDLE cycle. The capture
        // takes priority over a start arriving in that cycle, and it wraps the counters itself.
        if (group_end) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
          rb_acc   <= '0;
          gi       <= '0;
        end else begin
          rb_acc <= rb_next;
          gi     <= gi + 1'b1;
        end
        if (cc == BC_LAST) begin
          cc <= '0;
        end else begin
          cc <= cc + 1'b1;
        end
      end else if (do_start) begin
        // A timed-out load can leave a partial group behind. It is dropped here.
        rb_acc <= '0;
        gi     <= '0;
        cc     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NG = (CL + WW - 1) / WW;

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        start;
  logic        abort;
  logic [WW-1:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        config_enable;
  logic        ccff_head;
  logic        ccff_tail;
  logic [WW-1:0] rb_data;
  logic        rb_valid;
  logic        busy;
  logic        done;
  logic        err;

  // Second instance with a short timeout. It shares the stimulus with the main instance.
  logic        to_tail;
  logic        to_cfg_ready;
  logic        to_config_enable;
  logic        to_ccff_head;
  logic [WW-1:0] to_rb_data;
  logic        to_rb_valid;
  logic        to_busy;
  logic        to_done;
  logic        to_err;

  assign to_tail = 1'b0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .TIMEOUT(255)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .config_enable(config_enable), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done), .err(err)
  );

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .TIMEOUT(4)) dut_to (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(to_cfg_ready),
    .config_enable(to_config_enable), .ccff_head(to_ccff_head), .ccff_tail(to_tail),
    .rb_data(to_rb_data), .rb_valid(to_rb_valid), .busy(to_busy), .done(to_done), .err(to_err)
  );

  // Physical chain of the tile row, preloaded with all ones.
  logic [CL-1:0] chain = {CL{1'b1}};
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) begin
    if (config_enable) chain <= {chain[CL-2:0], ccff_head};
  end

  // Monitor. It samples mid-cycle, and the queues only grow.
  int   cyc = 0;
  logic head_q[$];
  int   en_cyc_q[$];
  logic [WW-1:0] rb_q[$];
  always @(negedge prog_clk) begin
    cyc++;
    if (config_enable) begin
      head_q.push_back(ccff_head);
      en_cyc_q.push_back(cyc);
    end
    if (rb_valid) rb_q.push_back(rb_data);
  end

  // Reference model: chain contents as a bit list in shift-out order.
  bit model_chain[$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0][WW-1:0] w;
    int g0, g1, g2;
    bit ms;
    bit has_exp;
    logic [CL-1:0] exp_head;
    logic [2:0][WW-1:0] exp_rb;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge prog_clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [WW-1:0] a, b, c, input int g0, g1, g2,
                               input bit ms, input bit he, input logic [CL-1:0] eh,
                               input logic [WW-1:0] r0, r1, r2);
    vec_t v;
    v.w = {c, b, a};
    v.g0 = g0; v.g1 = g1; v.g2 = g2;
    v.ms = ms; v.has_exp = he; v.exp_head = eh;
    v.exp_rb = {r2, r1, r0};
    return v;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds cfg_valid low for 'gap' starved FETCH cycles and then hands over one word.
  // The optional start pulse lands while the previous word is still shifting.
  task automatic send_word(input logic [WW-1:0] w, input int gap, input bit ms);
    int n = 0;
    cfg_valid = 1'b0;
    while (!cfg_ready && n < 200) begin
      if (ms && n == 2) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    if (n >= 200) chk("fetch_wait", {31'b0, cfg_ready}, 32'd1);
    repeat (gap) tick();
    cfg_data  = w;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input vec_t v);
    int h0, e0, r0, n, ng;
    bit bits[$];
    logic [WW-1:0] exp_rb[$];
    logic [31:0] act_h, exp_h;
    h0 = head_q.size(); e0 = en_cyc_q.size(); r0 = rb_q.size();

    // Expected readback: the current chain contents, grouped and zero-padded.
    for (int i = 0; i < CL; i += WW) begin
      logic [WW-1:0] g = '0;
      for (int j = 0; j < WW; j++) if (i + j < CL) g[j] = model_chain[i + j];
      exp_rb.push_back(g);
    end
    // Expected chain input: the words LSB first, truncated to the chain length.
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < WW; j++)
        if (bits.size() < CL) bits.push_back(v.w[k][j]);

    pulse_start();
    send_word(v.w[0], v.g0, 1'b0);
    send_word(v.w[1], v.g1, v.ms);
    send_word(v.w[2], v.g2, v.ms);
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    repeat (3) tick();

    chk({tag, "_en_cycles"}, head_q.size() - h0, CL);
    act_h = '0; exp_h = '0;
    for (int i = 0; i < CL; i++) begin
      exp_h[i] = bits[i];
      if (h0 + i < head_q.size()) act_h[i] = head_q[h0 + i];
    end
    chk({tag, "_head_seq"}, act_h, exp_h);
    if (v.has_exp) chk({tag, "_head_const"}, act_h, {12'b0, v.exp_head});
    // Each word boundary costs one FETCH cycle, and every starved cycle adds one more.
    if (en_cyc_q.size() - e0 >= CL)
      chk({tag, "_bubbles"}, en_cyc_q[e0 + CL - 1] - en_cyc_q[e0] + 1 - CL, 2 + v.g1 + v.g2);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    ng = rb_q.size() - r0;
    chk({tag, "_rb_count"}, ng, NG);
    for (int i = 0; i < NG; i++) begin
      logic [31:0] a;
      a = (r0 + i < rb_q.size()) ? {24'b0, rb_q[r0 + i]} : 32'hDEAD;
      chk({tag, "_rb_model"}, a, {24'b0, exp_rb[i]});
      if (v.has_exp) chk({tag, "_rb_const"}, a, {24'b0, v.exp_rb[i]});
    end
    model_chain = bits;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cfg_ready"}, {31'b0, cfg_ready}, 32'd0);
    chk({tag, "_cfg_en"}, {31'b0, config_enable}, 32'd0);
    chk({tag, "_head"}, {31'b0, ccff_head}, 32'd0);
    chk({tag, "_rb_data"}, {24'b0, rb_data}, 32'd0);
    chk({tag, "_rb_valid"}, {31'b0, rb_valid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_to_busy"}, {31'b0, to_busy}, 32'd0);
    chk({tag, "_to_err"}, {31'b0, to_err}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int n, rdy, h0, r0;
    vec_t rv;
    pReset = 1'b1; start = 1'b0; abort = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
    for (int i = 0; i < CL; i++) model_chain.push_back(1'b1);

    tbl[0] = mkv(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 0, 1, 20'hF3CA5, 8'hFF, 8'hFF, 8'h0F);
    tbl[1] = mkv(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 0, 1, 20'hF3CA5, 8'hA5, 8'h3C, 8'h0F);
    tbl[2] = mkv(8'h5A, 8'hC3, 8'hF0, 0, 5, 0, 0, 1, 20'h0C35A, 8'hA5, 8'h3C, 8'h0F);
    tbl[3] = mkv(8'h12, 8'h34, 8'h56, 2, 0, 3, 1, 0, '0, '0, '0, '0);
    tbl[4] = mkv(8'hFF, 8'h00, 8'hAA, 0, 1, 1, 1, 0, '0, '0, '0, '0);

    // Reset state
    repeat (3) tick();
    chk_reset_outs("rst_hold");
    pReset = 1'b0;
    repeat (2) tick();
    chk_reset_outs("rst_rel");

    // Directed table
    for (int t = 0; t < 5; t++) do_load($sformatf("tbl%0d", t), tbl[t]);

    // Random loads against the model
    for (int t = 0; t < 10; t++) begin
      rv = mkv(WW'($urandom), WW'($urandom), WW'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), 0, '0, '0, '0, '0);
      do_load($sformatf("rnd%0d", t), rv);
    end

    // Timeout on the short-timeout instance: the second word never arrives.
    pReset = 1'b1; tick(); pReset = 1'b0; tick();
    pulse_start();
    send_word(8'h77, 0, 1'b0);
    n = 0; rdy = 0;
    while (!to_err && n < 40) begin
      if (to_cfg_ready) rdy++;
      tick(); n++;
    end
    chk("to_err", {31'b0, to_err}, 32'd1);
    chk("to_starved", rdy, 4);
    chk("to_busy", {31'b0, to_busy}, 32'd0);
    chk("to_done", {31'b0, to_done}, 32'd0);
    chk("to_cfg_en", {31'b0, to_config_enable}, 32'd0);
    pulse_start();
    chk("to_err_clr", {31'b0, to_err}, 32'd0);
    chk("to_restart", {31'b0, to_busy}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("abort_idle", {31'b0, busy}, 32'd0);

    // Abort after ten enabled shifts
    h0 = head_q.size(); r0 = rb_q.size();
    pulse_start();
    send_word(8'hC6, 0, 1'b0);
    cfg_data = 8'h39; cfg_valid = 1'b1;
    n = 0;
    while (head_q.size() - h0 < 10 && n < 60) begin tick(); n++; end
    abort = 1'b1; cfg_valid = 1'b0;
    tick();
    abort = 1'b0;
    chk("ab_cfg_en", {31'b0, config_enable}, 32'd0);
    chk("ab_busy", {31'b0, busy}, 32'd0);
    repeat (15) tick();
    chk("ab_shifts", head_q.size() - h0, 10);
    chk("ab_rb_count", rb_q.size() - r0, 1);
    chk("ab_done", {31'b0, done}, 32'd0);
    chk("ab_err", {31'b0, err}, 32'd0);

    // Asynchronous reset in the middle of SHIFT
    pulse_start();
    send_word(8'h81, 0, 1'b0);
    repeat (3) tick();
    chk("mr_busy_pre", {31'b0, busy}, 32'd1);
    chk("mr_en_pre", {31'b0, config_enable}, 32'd1);
    #2;
    pReset = 1'b1;
    #1;
    chk_reset_outs("mr");
    tick();
    pReset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
